// File: rtl/temporizador_preset_if.sv
// Bundle of preset, command and status signals between the irrigation
// control FSM (master) and the countdown timer (slave).
//
// Command semantics: carregar/iniciar/pausa/cancelar are level inputs sampled
// on every rising clk edge. There is no valid/ready pairing: a command is
// acted on at the edge where it is high, and holding it simply re-applies it.
// Every status output (digits, ativo, fim, erro, estado) is registered.
interface temporizador_preset_if;
  logic [3:0] dez_minutopreset;
  logic [3:0] unid_minutopreset;
  logic [3:0] dez_segundopreset;
  logic [3:0] unid_segundopreset;
  logic       carregar;
  logic       iniciar;
  logic       pausa;
  logic       cancelar;
  logic [3:0] dez_minuto;
  logic [3:0] unid_minuto;
  logic [3:0] dez_segundo;
  logic [3:0] unid_segundo;
  logic       ativo;
  logic       fim;
  logic       erro;
  // Debug view of the timer FSM: 0 OCIOSO, 1 CONTANDO, 2 PAUSADO, 3 FIM.
  logic [1:0] estado;

  modport master (
    output dez_minutopreset, unid_minutopreset, dez_segundopreset, unid_segundopreset,
    output carregar, iniciar, pausa, cancelar,
    input  dez_minuto, unid_minuto, dez_segundo, unid_segundo,
    input  ativo, fim, erro, estado
  );

  modport slave (
    input  dez_minutopreset, unid_minutopreset, dez_segundopreset, unid_segundopreset,
    input  carregar, iniciar, pausa, cancelar,
    output dez_minuto, unid_minuto, dez_segundo, unid_segundo,
    output ativo, fim, erro, estado
  );
endinterface

// File: rtl/temporizador_preset.sv
// BCD MM:SS countdown timer. Loads and validates a preset, then decrements
// one second per prescaled tick down to 00:00, driving the valve-active flag
// and a one-cycle end-of-cycle pulse.
module temporizador_preset #(
  parameter int DIV_TICK = 50000000,
  parameter int LARG_DIV = 26
) (
  input  logic                   clk,
  input  logic                   reset_n,
  temporizador_preset_if.slave   bus
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [LARG_DIV-1:0] PRESC_MAX = LARG_DIV'(DIV_TICK - 1);

  estado_t             state_q, state_d;
  logic [3:0]          dm_q, dm_d, um_q, um_d, ds_q, ds_d, us_q, us_d;
  logic [LARG_DIV-1:0] presc_q, presc_d;
  logic                ativo_q, ativo_d, fim_q, fim_d, erro_q, erro_d;

  logic [3:0] dec_dm, dec_um, dec_ds, dec_us;
  logic       dec_zero, digits_zero, preset_ok, tick;

  // One-second BCD decrement with borrow; only used when the count is nonzero.
  always_comb begin
    dec_dm = dm_q;
    dec_um = um_q;
    dec_ds = ds_q;
    dec_us = us_q;
    if (us_q != 4'd0) begin
      dec_us = us_q - 4'd1;
    end else begin
      dec_us = 4'd9;
      if (ds_q != 4'd0) begin
        dec_ds = ds_q - 4'd1;
      end else begin
        dec_ds = 4'd5;
        if (um_q != 4'd0) begin
          dec_um = um_q - 4'd1;
        end else begin
          dec_um = 4'd9;
          dec_dm = dm_q - 4'd1;
        end
      end
    end
  end

  assign dec_zero    = (dec_dm == 4'd0) && (dec_um == 4'd0) && (dec_ds == 4'd0) && (dec_us == 4'd0);
  assign digits_zero = (dm_q == 4'd0) && (um_q == 4'd0) && (ds_q == 4'd0) && (us_q == 4'd0);
  assign preset_ok   = (bus.dez_minutopreset <= 4'd5) && (bus.unid_minutopreset <= 4'd9) &&
                       (bus.dez_segundopreset <= 4'd5) && (bus.unid_segundopreset <= 4'd9);
  assign tick        = (presc_q == PRESC_MAX);

  // Next-state and registered-output logic; command priority
  // cancelar > carregar > pausa > iniciar.
  always_comb begin
    state_d = state_q;
    dm_d    = dm_q;
    um_d    = um_q;
    ds_d    = ds_q;
    us_d    = us_q;
    presc_d = presc_q;
    ativo_d = ativo_q;
    fim_d   = 1'b0;
    erro_d  = erro_q;

    if (bus.cancelar) begin
      state_d = OCIOSO;
      {dm_d, um_d, ds_d, us_d} = 16'h0000;
      presc_d = '0;
      ativo_d = 1'b0;
      erro_d  = 1'b0;
    end else begin
      case (state_q)
        OCIOSO, FIM: begin
          ativo_d = 1'b0;
          if (bus.carregar) begin
            state_d = OCIOSO;
            presc_d = '0;
            if (preset_ok) begin
              dm_d   = bus.dez_minutopreset;
              um_d   = bus.unid_minutopreset;
              ds_d   = bus.dez_segundopreset;
              us_d   = bus.unid_segundopreset;
              erro_d = 1'b0;
            end else begin
              {dm_d, um_d, ds_d, us_d} = 16'h0000;
              erro_d = 1'b1;
            end
          end else if (state_q == OCIOSO && !bus.pausa && bus.iniciar) begin
            presc_d = '0;
            if (digits_zero) begin
              state_d = FIM;
              fim_d   = 1'b1;
            end else begin
              state_d = CONTANDO;
              ativo_d = 1'b1;
            end
          end
        end
        CONTANDO: begin
          if (tick) begin
            presc_d = '0;
            dm_d    = dec_dm;
            um_d    = dec_um;
            ds_d    = dec_ds;
            us_d    = dec_us;
            if (dec_zero) begin
              state_d = FIM;
              fim_d   = 1'b1;
              ativo_d = 1'b0;
            end else if (bus.pausa) begin
              state_d = PAUSADO;
              ativo_d = 1'b0;
            end
          end else if (bus.pausa) begin
            state_d = PAUSADO;
            ativo_d = 1'b0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSADO: begin
          // Prescaler is left untouched so the sub-second fraction survives.
          if (!bus.pausa && bus.iniciar) begin
            state_d = CONTANDO;
            ativo_d = 1'b1;
          end
        end
        default: begin
          state_d = OCIOSO;
          ativo_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OCIOSO;
      dm_q    <= 4'd0;
      um_q    <= 4'd0;
      ds_q    <= 4'd0;
      us_q    <= 4'd0;
      presc_q <= '0;
      ativo_q <= 1'b0;
      fim_q   <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dm_q    <= dm_d;
      um_q    <= um_d;
      ds_q    <= ds_d;
      us_q    <= us_d;
      presc_q <= presc_d;
      ativo_q <= ativo_d;
      fim_q   <= fim_d;
      erro_q  <= erro_d;
    end
  end

  assign bus.dez_minuto   = dm_q;
  assign bus.unid_minuto  = um_q;
  assign bus.dez_segundo  = ds_q;
  assign bus.unid_segundo = us_q;
  assign bus.ativo        = ativo_q;
  assign bus.fim          = fim_q;
  assign bus.erro         = erro_q;
  assign bus.estado       = state_q;

endmodule
